// File: rtl/bcd_timer_pkg.sv
// Shared constants and types for the BCD hh:mm:ss timer.
// Digit limits, field offsets in the packed 24-bit time word.
package bcd_timer_pkg;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  localparam int S_U_OFF = 0;
  localparam int S_T_OFF = 4;
  localparam int M_U_OFF = 8;
  localparam int M_T_OFF = 12;
  localparam int H_U_OFF = 16;
  localparam int H_T_OFF = 20;

  typedef struct packed {
    logic [3:0] h_t;
    logic [3:0] h_u;
    logic [3:0] m_t;
    logic [3:0] m_u;
    logic [3:0] s_t;
    logic [3:0] s_u;
  } bcd_time_t;

endpackage

// File: rtl/bcd_digit.sv
// One up/down decade digit with parameterised max value.
// Load wins over inc/dec; co flags carry (inc) or borrow (dec).
module bcd_digit
  import bcd_timer_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       co
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  assign co = (inc && (q == MAX)) ||
              (dec && (q == 4'd0));

endmodule

// File: rtl/bcd_timer.sv
// BCD hh:mm:ss up/down timer built from six chained decade digits.
// Full-range wrap is done by a parallel load of zero or the max value.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int HOURS_EN     = 0,
  parameter int HOURS_MAX    = 23,
  parameter int STOP_AT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse,
  input  logic        enable,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_value,
  output logic [23:0] time_bcd,
  output logic        wrap,
  output logic        expired,
  output logic        load_err
);

  localparam logic [3:0] HM_T = 4'(HOURS_MAX / 10);
  localparam logic [3:0] HM_U = 4'(HOURS_MAX % 10);
  localparam logic [7:0] HM_BCD = {HM_T, HM_U};
  localparam logic [23:0] MAX_T =
    {(HOURS_EN != 0) ? HM_BCD : 8'h00, 16'h5959};

  typedef enum logic {RUN, EXPIRED} state_t;
  state_t state;

  logic [23:0] cur;
  logic [23:0] lv_eff;
  logic [23:0] dig_lv;
  logic tick, up, dn;
  logic at_max, at_zero, at_one;
  logic wrap_up, wrap_dn;
  logic hrs_ok, load_ok, dig_load;
  logic top_co_unused;

  assign tick = pulse & enable & ~load &
                (state == RUN);
  assign up = tick & ~dir;
  assign dn = tick & dir;

  assign at_max  = (cur == MAX_T);
  assign at_zero = (cur == 24'h0);
  assign at_one  = (cur == 24'h1);

  assign wrap_up = up & at_max;
  assign wrap_dn = dn & at_zero &
                   (STOP_AT_ZERO == 0);

  // Hours compared as a BCD pair: valid digits order like numbers.
  assign hrs_ok = (HOURS_EN == 0) ||
    ((load_value[H_T_OFF +: 4] <= UNIT_MAX) &&
     (load_value[H_U_OFF +: 4] <= UNIT_MAX) &&
     (load_value[H_U_OFF +: 8] <= HM_BCD));

  assign load_ok = hrs_ok &&
    (load_value[S_U_OFF +: 4] <= UNIT_MAX) &&
    (load_value[S_T_OFF +: 4] <= TENS_MAX) &&
    (load_value[M_U_OFF +: 4] <= UNIT_MAX) &&
    (load_value[M_T_OFF +: 4] <= TENS_MAX);

  assign lv_eff = (HOURS_EN != 0) ? load_value
                : {8'h00, load_value[15:0]};

  assign dig_load = (load & load_ok) |
                    wrap_up | wrap_dn;
  assign dig_lv = load    ? lv_eff :
                  wrap_up ? 24'h0  : MAX_T;

  for (genvar i = 0; i < 6; i++) begin : g
    localparam logic [3:0] DMAX =
      (i == 1 || i == 3) ? TENS_MAX : UNIT_MAX;
    logic inc_i, dec_i, co_i;
    logic [3:0] q_i;

    if (i == 0) begin : g_first
      assign inc_i = up & ~at_max;
      assign dec_i = dn & ~at_zero;
    end else begin : g_chain
      assign inc_i = g[i-1].inc_i & g[i-1].co_i;
      assign dec_i = g[i-1].dec_i & g[i-1].co_i;
    end

    bcd_digit #(.MAX(DMAX)) u_digit (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc_i),
      .dec      (dec_i),
      .load     (dig_load),
      .load_val (dig_lv[i*4 +: 4]),
      .q        (q_i),
      .co       (co_i)
    );

    assign cur[i*4 +: 4] = q_i;
  end

  assign top_co_unused = g[5].co_i;
  assign time_bcd = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wrap     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_up | wrap_dn;
      load_err <= load & ~load_ok;
      unique case (state)
        RUN: begin
          if (dn && at_one && (STOP_AT_ZERO != 0)) begin
            state   <= EXPIRED;
            expired <= 1'b1;
          end
        end
        EXPIRED: begin
          if (load && load_ok) begin
            state   <= RUN;
            expired <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer: two configurations share stimulus,
// a seconds-based reference model feeds an expected-value queue.
module tb_bcd_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pulse, enable, dir, load;
  logic [23:0] load_value;

  logic [23:0] time_h, time_m;
  logic        wrap_h, wrap_m;
  logic        expired_h, expired_m;
  logic        load_err_h, load_err_m;

  int n_assert = 0;
  int n_fail   = 0;

  int sec_h, sec_m;
  bit ex_h, ex_m;

  typedef struct {
    string       tag;
    int          id;
    logic [26:0] exp_v;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  bcd_timer #(
    .HOURS_EN(1), .HOURS_MAX(23), .STOP_AT_ZERO(1)
  ) dut_h (
    .clk(clk), .rst(rst), .pulse(pulse),
    .enable(enable), .dir(dir), .load(load),
    .load_value(load_value), .time_bcd(time_h),
    .wrap(wrap_h), .expired(expired_h),
    .load_err(load_err_h)
  );

  bcd_timer #(
    .HOURS_EN(0), .HOURS_MAX(23), .STOP_AT_ZERO(0)
  ) dut_m (
    .clk(clk), .rst(rst), .pulse(pulse),
    .enable(enable), .dir(dir), .load(load),
    .load_value(load_value), .time_bcd(time_m),
    .wrap(wrap_m), .expired(expired_m),
    .load_err(load_err_m)
  );

  function automatic logic [23:0] sec2bcd(int s);
    int h, m, ss;
    h  = s / 3600;
    m  = (s / 60) % 60;
    ss = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10),
            4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit valid(logic [23:0] v, bit hen, int hmax);
    bit ok;
    ok = (v[3:0] <= 9) && (v[7:4] <= 5) &&
         (v[11:8] <= 9) && (v[15:12] <= 5);
    if (hen)
      ok = ok && (v[19:16] <= 9) && (v[23:20] <= 9) &&
           (int'(v[23:20]) * 10 + int'(v[19:16]) <= hmax);
    return ok;
  endfunction

  function automatic int bcd2sec(logic [23:0] v, bit hen);
    int h;
    h = hen ? int'(v[23:20]) * 10 + int'(v[19:16]) : 0;
    return h * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_step(input bit hen, input int hmax,
                            input bit stop, inout int sec,
                            inout bit ex,
                            output logic [26:0] e);
    int period;
    bit w, le;
    period = hen ? (hmax + 1) * 3600 : 3600;
    w = 0;
    le = 0;
    if (load) begin
      if (valid(load_value, hen, hmax)) begin
        sec = bcd2sec(load_value, hen);
        ex  = 0;
      end else begin
        le = 1;
      end
    end else if (pulse && enable && !ex) begin
      if (!dir) begin
        if (sec == period - 1) begin
          sec = 0;
          w = 1;
        end else begin
          sec++;
        end
      end else if (sec == 0) begin
        if (!stop) begin
          sec = period - 1;
          w = 1;
        end
      end else begin
        sec--;
        if (sec == 0 && stop) ex = 1;
      end
    end
    e = {sec2bcd(sec), w, ex, le};
  endtask

  task automatic cycle(input string tag);
    logic [26:0] e;
    logic [26:0] obs;
    sb_t s;
    model_step(1, 23, 1, sec_h, ex_h, e);
    s.tag = tag; s.id = 0; s.exp_v = e;
    sb_q.push_back(s);
    model_step(0, 23, 0, sec_m, ex_m, e);
    s.tag = tag; s.id = 1; s.exp_v = e;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      obs = (s.id == 0)
        ? {time_h, wrap_h, expired_h, load_err_h}
        : {time_m, wrap_m, expired_m, load_err_m};
      n_assert++;
      assert (obs === s.exp_v) else begin
        n_fail++;
        $error("FAIL %s dut%0d observed %h expected %h",
               s.tag, s.id, obs, s.exp_v);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    logic [26:0] oh, om;
    oh = {time_h, wrap_h, expired_h, load_err_h};
    om = {time_m, wrap_m, expired_m, load_err_m};
    n_assert++;
    assert (oh === 27'h0) else begin
      n_fail++;
      $error("FAIL %s dut0 observed %h expected 0", tag, oh);
    end
    n_assert++;
    assert (om === 27'h0) else begin
      n_fail++;
      $error("FAIL %s dut1 observed %h expected 0", tag, om);
    end
  endtask

  task automatic ticks(input int n, input string tag);
    repeat (n) begin
      pulse = 1'b1;
      cycle(tag);
      pulse = 1'b0;
      cycle(tag);
    end
  endtask

  task automatic do_load(input logic [23:0] v,
                         input string tag);
    load = 1'b1;
    load_value = v;
    cycle(tag);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pulse = 1'b0;
    enable = 1'b0;
    dir = 1'b0;
    load = 1'b0;
    load_value = 24'h0;
    sec_h = 0; sec_m = 0;
    ex_h = 0; ex_m = 0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b1;

    ticks(3600, "up3600");

    do_load(24'h235959, "ld235959");
    ticks(1, "upwrap");

    dir = 1'b1;
    do_load(24'h000002, "ld000002");
    ticks(3, "down_expire");
    do_load(24'h000100, "ld000100");

    do_load(24'h006A00, "ld_bad_digit");
    do_load(24'h240000, "ld_bad_hours");

    dir = 1'b0;
    pulse = 1'b1;
    do_load(24'h001000, "ld_pulse");
    pulse = 1'b0;
    cycle("ld_pulse_after");

    enable = 1'b0;
    ticks(3, "paused");
    do_load(24'h000500, "ld_paused");
    enable = 1'b1;
    dir = 1'b1;
    ticks(1, "dir_down");
    dir = 1'b0;
    ticks(1, "dir_up");

    do_load(24'h195959, "ld195959");
    ticks(1, "hour_carry");
    dir = 1'b1;
    ticks(1, "hour_borrow");

    do_load(24'h000000, "ld_zero");
    ticks(2, "down_at_zero");

    dir = 1'b0;
    do_load(24'h004520, "ld004520");
    ticks(10, "to004530");

    pulse = 1'b1;
    load = 1'b1;
    load_value = 24'h123456;
    #2 rst = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_held");
    #2 rst = 1'b1;
    pulse = 1'b0;
    load = 1'b0;
    sec_h = 0; sec_m = 0;
    ex_h = 0; ex_m = 0;
    ticks(5, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
